// File: rtl/csr_file_if.sv
// csr_file_if: EX-stage CSR access bus (request, read-modify-write operands, old value and illegal flag).
interface csr_file_if;
   logic        csr_req_i;
   logic [1:0]  csr_op_i;
   logic [11:0] csr_addr_i;
   logic [31:0] csr_wdata_i;
   logic        csr_wsup_i;
   logic [31:0] csr_rdata_o;
   logic        csr_illegal_o;
   modport master (output csr_req_i, csr_op_i, csr_addr_i, csr_wdata_i, csr_wsup_i,
                   input  csr_rdata_o, csr_illegal_o);
   modport slave  (input  csr_req_i, csr_op_i, csr_addr_i, csr_wdata_i, csr_wsup_i,
                   output csr_rdata_o, csr_illegal_o);
endinterface

// File: rtl/csr_file.sv
// csr_file: RV32 machine-mode CSR file with trap/MRET updates, cycle/instret counters and interrupt request.
// Define CSR_HPM_EN to implement mhpmcounter3.. at 0xB03/0xB83 onwards.
module csr_file #(
   parameter int          CNT_WIDTH = 64,
   parameter int          NUM_HPM   = 4,
   parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
   parameter int          HART_ID   = 0
) (
   input  logic               clk,
   input  logic               rst,
   csr_file_if.slave          csr,
   input  logic               trap_i,
   input  logic [31:0]        trap_cause_i,
   input  logic [31:0]        trap_epc_i,
   input  logic [31:0]        trap_tval_i,
   input  logic               mret_i,
   input  logic               instret_i,
   input  logic               irq_ext_i,
   input  logic               irq_timer_i,
   input  logic               irq_soft_i,
   input  logic [NUM_HPM-1:0] hpm_event_i,
   output logic [31:0]        mtvec_o,
   output logic [31:0]        mepc_o,
   output logic               irq_req_o,
   output logic [31:0]        irq_cause_o
);
   logic                 mie_bit_q, mie_bit_d, mpie_q, mpie_d;
   logic [31:0]          mie_q, mie_d, mtvec_q, mtvec_d, mcinh_q, mcinh_d;
   logic [31:0]          mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
   logic [CNT_WIDTH-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
   logic [63:0]          cyc64, ins64;
   logic [31:0]          mstatus, mip, pend, rd, wval;
   logic [11:0]          a;
   logic                 valid, hpm_rng, wr_op, illegal, we;

   // A write to one half wins over the increment and leaves the other half untouched.
   function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cur,
      input logic inc, input logic wr_lo, input logic wr_hi, input logic [31:0] v);
      logic [63:0] c;
      c = 64'(cur);
      c = wr_lo ? {c[63:32], v} : wr_hi ? {v, c[31:0]} : inc ? 64'(cur + CNT_WIDTH'(1)) : c;
      return c[CNT_WIDTH-1:0];
   endfunction

`ifdef CSR_HPM_EN
   localparam logic [31:0] CINH_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);
   logic [CNT_WIDTH-1:0] hpm_q [NUM_HPM];
   logic [CNT_WIDTH-1:0] hpm_d [NUM_HPM];
   logic [63:0]          hpm64 [NUM_HPM];
   always_comb begin
      for (int k = 0; k < NUM_HPM; k++) begin
         hpm64[k] = 64'(hpm_q[k]);
         hpm_d[k] = cnt_next(hpm_q[k], hpm_event_i[k] && !mcinh_q[k + 3],
                             we && a == 12'hB03 + 12'(k), we && a == 12'hB83 + 12'(k), wval);
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      for (int k = 0; k < NUM_HPM; k++) hpm_q[k] <= !rst ? '0 : hpm_d[k];
   end
`else
   localparam logic [31:0] CINH_MASK = 32'h5;
   logic unused_hpm;
   assign unused_hpm = ^hpm_event_i;
`endif

   assign a       = csr.csr_addr_i;
   assign cyc64   = 64'(mcycle_q);
   assign ins64   = 64'(minstret_q);
   assign mstatus = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_bit_q, 3'b0};
   assign mip     = {20'b0, irq_ext_i, 3'b0, irq_timer_i, 3'b0, irq_soft_i, 3'b0};
   assign pend    = mie_q & mip;
   assign hpm_rng = a[11:8] == 4'hB && (a[7:5] == 3'b000 || a[7:5] == 3'b100) && a[4:0] >= 5'd3;

   always_comb begin
      rd    = '0;
      valid = 1'b1;
      case (a)
         12'h300:          rd = mstatus;
         12'h301:          rd = 32'h4000_0100;
         12'h304:          rd = mie_q;
         12'h305:          rd = mtvec_q;
         12'h320:          rd = mcinh_q;
         12'h340:          rd = mscratch_q;
         12'h341:          rd = mepc_q;
         12'h342:          rd = mcause_q;
         12'h343:          rd = mtval_q;
         12'h344:          rd = mip;
         12'hB00, 12'hC00: rd = cyc64[31:0];
         12'hB80, 12'hC80: rd = cyc64[63:32];
         12'hB02, 12'hC02: rd = ins64[31:0];
         12'hB82, 12'hC82: rd = ins64[63:32];
         12'hF14:          rd = 32'(HART_ID);
         default:          valid = hpm_rng;
      endcase
`ifdef CSR_HPM_EN
      for (int k = 0; k < NUM_HPM; k++)
         if (hpm_rng && a[4:0] == 5'(k + 3)) rd = a[7] ? hpm64[k][63:32] : hpm64[k][31:0];
`endif
   end

   // RS/RC with a zero source are pure reads, so they stay legal on read-only CSRs.
   assign wr_op   = csr.csr_op_i != 2'b00 && !(csr.csr_op_i[1] && csr.csr_wsup_i);
   assign illegal = csr.csr_req_i && (!valid || (a[11:10] == 2'b11 && wr_op));
   assign we      = csr.csr_req_i && wr_op && !illegal;
   assign wval    = csr.csr_op_i == 2'b01 ? csr.csr_wdata_i :
                    csr.csr_op_i == 2'b10 ? rd | csr.csr_wdata_i : rd & ~csr.csr_wdata_i;

   assign csr.csr_rdata_o   = illegal ? 32'h0 : rd;
   assign csr.csr_illegal_o = illegal;
   assign mtvec_o           = mtvec_q;
   assign mepc_o            = mepc_q;
   assign irq_req_o         = mie_bit_q && |pend;
   assign irq_cause_o       = pend[11] ? 32'h8000_000B : pend[3] ? 32'h8000_0003 :
                              pend[7]  ? 32'h8000_0007 : 32'h0;

   // Later assignments take priority: trap over MRET over software.
   always_comb begin
      mie_bit_d = we && a == 12'h300 ? wval[3] : mie_bit_q;
      mpie_d    = we && a == 12'h300 ? wval[7] : mpie_q;
      if (mret_i) begin
         mie_bit_d = mpie_q;
         mpie_d    = 1'b1;
      end
      if (trap_i) begin
         mpie_d    = mie_bit_q;
         mie_bit_d = 1'b0;
      end
      mie_d      = we && a == 12'h304 ? wval & 32'h888 : mie_q;
      mtvec_d    = we && a == 12'h305 ? wval & ~32'h2 : mtvec_q;
      mcinh_d    = we && a == 12'h320 ? wval & CINH_MASK : mcinh_q;
      mscratch_d = we && a == 12'h340 ? wval : mscratch_q;
      mepc_d     = trap_i ? trap_epc_i & ~32'h3 : we && a == 12'h341 ? wval & ~32'h3 : mepc_q;
      mcause_d   = trap_i ? trap_cause_i : we && a == 12'h342 ? wval : mcause_q;
      mtval_d    = trap_i ? trap_tval_i : we && a == 12'h343 ? wval : mtval_q;
      mcycle_d   = cnt_next(mcycle_q, !mcinh_q[0], we && a == 12'hB00, we && a == 12'hB80, wval);
      minstret_d = cnt_next(minstret_q, instret_i && !mcinh_q[2], we && a == 12'hB02,
                            we && a == 12'hB82, wval);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mie_bit_q  <= 1'b0;
         mpie_q     <= 1'b0;
         mie_q      <= '0;
         mtvec_q    <= MTVEC_RST;
         mcinh_q    <= '0;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mie_bit_q  <= mie_bit_d;
         mpie_q     <= mpie_d;
         mie_q      <= mie_d;
         mtvec_q    <= mtvec_d;
         mcinh_q    <= mcinh_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed scoreboard bench for csr_file (expected {illegal, rdata} queued per access).
module tb_csr_file;
   localparam logic [1:0] RW = 2'b01, RS = 2'b10, RC = 2'b11;
   logic        clk, rst_n, trap_i, mret_i, instret_i, irq_ext_i, irq_timer_i, irq_soft_i;
   logic [31:0] trap_cause_i, trap_epc_i, trap_tval_i, mtvec_o, mepc_o, irq_cause_o;
   logic [3:0]  hpm_event_i;
   logic        irq_req_o;
   logic [32:0] exp_q [$];
   int          vectors = 0, miscompares = 0;

   csr_file_if bus ();

   csr_file #(.MTVEC_RST(32'h8000_0000)) dut (
      .clk(clk), .rst(rst_n), .csr(bus), .trap_i(trap_i), .trap_cause_i(trap_cause_i),
      .trap_epc_i(trap_epc_i), .trap_tval_i(trap_tval_i), .mret_i(mret_i), .instret_i(instret_i),
      .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i), .irq_soft_i(irq_soft_i),
      .hpm_event_i(hpm_event_i), .mtvec_o(mtvec_o), .mepc_o(mepc_o), .irq_req_o(irq_req_o),
      .irq_cause_o(irq_cause_o));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string t, input logic [32:0] obs);
      logic [32:0] e;
      e = exp_q.pop_front();
      vectors++;
      assert (obs === e) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
   endtask

   task automatic cmp(input string t, input logic [32:0] obs, input logic [32:0] e);
      exp_q.push_back(e);
      chk(t, obs);
   endtask

   // One CSR access cycle: expectation queued, outputs sampled mid-cycle, then the commit edge.
   task automatic acc(input string t, input logic [1:0] op, input logic [11:0] a,
                      input logic [31:0] wd, input logic ws, input logic chk_rd,
                      input logic eil, input logic [31:0] erd);
      exp_q.push_back({eil, chk_rd ? erd : 32'h0});
      bus.csr_req_i   = 1'b1;
      bus.csr_op_i    = op;
      bus.csr_addr_i  = a;
      bus.csr_wdata_i = wd;
      bus.csr_wsup_i  = ws;
      #2;
      chk(t, {bus.csr_illegal_o, chk_rd ? bus.csr_rdata_o : 32'h0});
      @(posedge clk);
      #1;
      bus.csr_req_i = 1'b0;
      bus.csr_op_i  = 2'b00;
   endtask

   task automatic rd(input string t, input logic [11:0] a, input logic [31:0] e);
      acc(t, RS, a, 32'h0, 1'b1, 1'b1, 1'b0, e);
   endtask

   task automatic wr(input string t, input logic [1:0] op, input logic [11:0] a,
                     input logic [31:0] wd, input logic [31:0] e);
      acc(t, op, a, wd, 1'b0, 1'b1, 1'b0, e);
   endtask

   initial begin
      rst_n = 1'b0; trap_i = 1'b0; mret_i = 1'b0; instret_i = 1'b0;
      irq_ext_i = 1'b0; irq_timer_i = 1'b0; irq_soft_i = 1'b0; hpm_event_i = '0;
      trap_cause_i = '0; trap_epc_i = '0; trap_tval_i = '0;
      bus.csr_req_i = 1'b0; bus.csr_op_i = 2'b00; bus.csr_addr_i = '0;
      bus.csr_wdata_i = '0; bus.csr_wsup_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cmp("rst_mtvec", {1'b0, mtvec_o}, {1'b0, 32'h8000_0000});
      cmp("rst_mepc", {1'b0, mepc_o}, 33'h0);
      cmp("rst_irq_req", {32'h0, irq_req_o}, 33'h0);
      cmp("rst_illegal", {32'h0, bus.csr_illegal_o}, 33'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      rd("mcycle_1", 12'hB00, 32'h1);
      rd("mcycle_2", 12'hB00, 32'h2);
      rd("mstatus_rst", 12'h300, 32'h1800);
      rd("mtvec_rst", 12'h305, 32'h8000_0000);
      wr("mie_rs", RS, 12'h304, 32'h888, 32'h0);
      wr("mie_rc", RC, 12'h304, 32'h080, 32'h888);
      rd("mie_final", 12'h304, 32'h808);
      wr("mie_rw", RW, 12'h304, 32'h888, 32'h808);
      wr("mstatus_set_mie", RS, 12'h300, 32'h8, 32'h1800);
      irq_ext_i = 1'b1; irq_soft_i = 1'b1; irq_timer_i = 1'b1;
      #1;
      cmp("irq_req_all", {32'h0, irq_req_o}, 33'h1);
      cmp("irq_cause_ext", {1'b0, irq_cause_o}, {1'b0, 32'h8000_000B});
      irq_ext_i = 1'b0;
      #1;
      cmp("irq_cause_soft", {1'b0, irq_cause_o}, {1'b0, 32'h8000_0003});
      irq_soft_i = 1'b0;
      #1;
      cmp("irq_cause_timer", {1'b0, irq_cause_o}, {1'b0, 32'h8000_0007});
      rd("mip_timer", 12'h344, 32'h80);
      trap_epc_i = 32'h104; trap_cause_i = 32'h8000_0007; trap_tval_i = 32'h55; trap_i = 1'b1;
      @(posedge clk);
      #1;
      trap_i = 1'b0;
      cmp("trap_mepc", {1'b0, mepc_o}, {1'b0, 32'h104});
      cmp("trap_irq_masked", {32'h0, irq_req_o}, 33'h0);
      rd("trap_mstatus", 12'h300, 32'h1880);
      rd("trap_mcause", 12'h342, 32'h8000_0007);
      rd("trap_mtval", 12'h343, 32'h55);
      mret_i = 1'b1;
      @(posedge clk);
      #1;
      mret_i = 1'b0;
      rd("mret_mstatus", 12'h300, 32'h1888);
      cmp("mret_irq_req", {32'h0, irq_req_o}, 33'h1);
      irq_timer_i = 1'b0;
      acc("mcycle_wr_lo", RW, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0);
      wr("mcycleh_wr", RW, 12'hB80, 32'h0, 32'h0);
      rd("mcycle_hold", 12'hB00, 32'hFFFF_FFFF);
      rd("mcycle_wrap", 12'hB00, 32'h0);
      rd("mcycleh_carry", 12'hB80, 32'h1);
      rd("minstret_0", 12'hB02, 32'h0);
      instret_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      instret_i = 1'b0;
      rd("minstret_3", 12'hB02, 32'h3);
      rd("minstreth_0", 12'hB82, 32'h0);
      wr("mcinh_set", RW, 12'h320, 32'h5, 32'h0);
      acc("mcycle_wr_100", RW, 12'hB00, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
      rd("mcycle_inh_a", 12'hB00, 32'h100);
      rd("mcycle_inh_b", 12'hB00, 32'h100);
      acc("cycle_rw_illegal", RW, 12'hC00, 32'h5, 1'b0, 1'b1, 1'b1, 32'h0);
      acc("cycle_rs_x0", RS, 12'hC00, 32'h0, 1'b1, 1'b1, 1'b0, 32'h100);
      acc("cycle_rs_illegal", RS, 12'hC00, 32'h1, 1'b0, 1'b1, 1'b1, 32'h0);
      rd("mcycle_untouched", 12'hB00, 32'h100);
      acc("unimpl_illegal", RS, 12'h7C0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0);
      rd("hpm_hole_rd", 12'hB1F, 32'h0);
      wr("hpm_hole_wr", RW, 12'hB1F, 32'hFFFF, 32'h0);
      rd("mhartid", 12'hF14, 32'h0);
      wr("misa_wr", RW, 12'h301, 32'h0, 32'h4000_0100);
      rd("misa_ro", 12'h301, 32'h4000_0100);
      wr("mcinh_clr", RW, 12'h320, 32'h0, 32'h5);
      wr("mepc_wr", RW, 12'h341, 32'h203, 32'h104);
      rd("mepc_align", 12'h341, 32'h200);
      wr("mtvec_wr", RW, 12'h305, 32'h1003, 32'h8000_0000);
      rd("mtvec_bit1", 12'h305, 32'h1001);
      trap_epc_i = 32'h300; trap_cause_i = 32'h2; trap_tval_i = 32'h0; trap_i = 1'b1;
      wr("mepc_vs_trap", RW, 12'h341, 32'h200, 32'h200);
      trap_i = 1'b0;
      cmp("trap_wins_mepc", {1'b0, mepc_o}, {1'b0, 32'h300});
      rd("trap2_mstatus", 12'h300, 32'h1880);
      wr("mscratch_wr", RW, 12'h340, 32'hABCD, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      cmp("async_mtvec", {1'b0, mtvec_o}, {1'b0, 32'h8000_0000});
      cmp("async_mepc", {1'b0, mepc_o}, 33'h0);
      rd("rst_mscratch", 12'h340, 32'h0);
      rd("rst_mie", 12'h304, 32'h0);
      rd("rst_mcycle", 12'hB00, 32'h0);
      rd("rst_mstatus", 12'h300, 32'h1800);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      rd("rerelease_mcycle", 12'hB00, 32'h1);
      rd("rerelease_mtvec", 12'h305, 32'h8000_0000);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/csr_file.md
# csr_file

Parametrised machine-mode CSR file for the RV32I pipeline core, sitting between the EX stage and the CLINT trap logic. It executes CSRRW/CSRRS/CSRRC read-modify-write operations, flags illegal accesses, performs hardware trap-entry and MRET state updates atomically, and maintains 64-bit cycle/instret counters and optional hardware performance counters. It computes the interrupt request to the CLINT from mstatus/mie/mip.

## Interface
Parameters:
- CNT_WIDTH, 64, implemented counter width (33..64); bits at and above CNT_WIDTH read 0
- NUM_HPM, 4, number of mhpmcounter3.. counters (0..29), used only with CSR_HPM_EN
- MTVEC_RST, 32'h0000_0000, mtvec reset value
- HART_ID, 0, value of mhartid

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- csr_req_i  in  1  EX stage CSR instruction valid this cycle
- csr_op_i  in  2  01 RW, 10 RS, 11 RC; 00 treated as no-op
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  32  rs1 value or zero-extended uimm
- csr_wsup_i  in  1  rs1/uimm field is x0/0; suppresses write for RS/RC only
- csr_rdata_o  out  32  old CSR value for rd
- csr_illegal_o  out  1  access illegal; no state change
- trap_i  in  1  trap entry pulse from CLINT
- trap_cause_i  in  32  mcause value
- trap_epc_i  in  32  faulting/interrupted PC
- trap_tval_i  in  32  mtval value
- mret_i  in  1  MRET retire pulse
- instret_i  in  1  one instruction retired this cycle
- irq_ext_i, irq_timer_i, irq_soft_i  in  1 each  level interrupt sources (MEIP, MTIP, MSIP)
- hpm_event_i  in  NUM_HPM  per-counter increment pulses
- mtvec_o, mepc_o  out  32  to CLINT/PC select
- irq_req_o  out  1  mstatus.MIE & |(mie & mip)
- irq_cause_o  out  32  cause of highest-priority pending enabled interrupt (MEI 11 > MSI 3 > MTI 7), bit31 set

## Operation
- Implemented CSRs: mstatus 0x300 (MIE bit3, MPIE bit7, MPP[12:11] reads 2'b11, others 0), misa 0x301 (read-only 0x4000_0100, writes ignored), mie 0x304 (bits 3/7/11 writable), mtvec 0x305 (bit1 forced 0), mcountinhibit 0x320 (bit0 CY, bit2 IR, bits 3+ HPM), mscratch 0x340, mepc 0x341 (bits[1:0] forced 0), mcause 0x342, mtval 0x343, mip 0x344 (read-only, reflects irq inputs, writes ignored), mcycle/h 0xB00/0xB80, minstret/h 0xB02/0xB82, cycle/instret(/h) 0xC00/0xC02/0xC80/0xC82 read-only shadows, mhartid 0xF14.
- New value: RW → wdata; RS → old | wdata; RC → old & ~wdata.
- Write occurs when csr_req_i, op≠00, no illegal, and not (op∈{RS,RC} & csr_wsup_i).
- csr_illegal_o=1 when csr_req_i and (address unimplemented, or addr[11:10]==2'b11 and a write would occur). csr_rdata_o=0 when illegal.
- Trap entry: mepc←trap_epc_i, mcause←trap_cause_i, mtval←trap_tval_i, MPIE←MIE, MIE←0.
- MRET: MIE←MPIE, MPIE←1.
- Priority same cycle: trap_i > mret_i > software write; lower-priority updates to overlapping fields are dropped, software writes to unrelated CSRs still commit.
- Counters: mcycle +1 each cycle unless inhibited; minstret +1 on instret_i unless inhibited. A software write to either half of a counter wins over that cycle's increment; the other half holds (no carry that cycle). Increment wraps at 2^CNT_WIDTH to 0.

## Timing
- csr_rdata_o, csr_illegal_o, irq_req_o, irq_cause_o combinational; read returns pre-write value.
- All updates commit at the next rising clk; visible to reads the following cycle.
- mip follows irq inputs with zero register stages.
- Reset (asynchronous, any cycle, including mid-operation): all CSRs 0 except mtvec=MTVEC_RST; counters 0; irq_req_o=0, csr_illegal_o=0 while no request; mtvec_o=MTVEC_RST, mepc_o=0.

## Configuration
- CSR_HPM_EN defined: mhpmcounter3..(3+NUM_HPM-1) at 0xB03.. (high halves 0xB83..) implemented, increment on hpm_event_i[k] unless mcountinhibit bit 3+k set; same write/wrap rules as mcycle.
- Undefined: those addresses and any remaining 0xB03–0xB1F/0xB83–0xB9F read 0, writes ignored, not illegal; hpm_event_i unused.

## Test plan
- Reset release, MTVEC_RST=0x8000_0000 → mtvec_o=0x8000_0000, mcycle reads 1 one cycle after first edge, 2 next.
- CSRRS mie, wdata 0x888, then CSRRC wdata 0x080 → reads 0x000 then 0x888; final mie=0x808.
- Set MIE, mie.MTIE, raise irq_timer_i → irq_req_o=1, irq_cause_o=0x8000_0007; trap_i with epc 0x104 → mepc=0x104, MIE=0, MPIE=1; mret_i → MIE=1.
- Write mcycle=0xFFFF_FFFF, mcycleh=0 → next cycle mcycleh=1, mcycle=0.
- CSRRW to 0xC00 → csr_illegal_o=1, counter unaffected; CSRRS 0xC00 with csr_wsup_i=1 → legal, returns cycle.
- trap_i and CSRRW mepc=0x200 same cycle → mepc=trap_epc_i; rst low mid-sequence → all CSRs return to reset values immediately.
